// File: rtl/lut_const_div_8bit.sv
// Divides a 16-bit dividend by a constant using a 16-entry multiple LUT, two radix-16 digits.
// Define LUT_DIV_OVF_CHECK_EN to enable quotient-overflow detection and forcing.
module lut_const_div_8bit #(
    parameter int unsigned A_const = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] C,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  X,
    output logic [7:0]  R,
    output logic        ovf
);

    typedef enum logic [1:0] {StIdle, StHi, StLo, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] p_q;
    logic [7:0]  x_q;
    logic        ovf_q;
    logic [15:0] lut [16];
    logic [3:0]  dig_hi, dig_lo;

    // Constant multiples d*A_const; max 15*255 fits in 12 bits, so <<4 stays within 16 bits.
    for (genvar d = 0; d < 16; d++) begin : g_lut
        assign lut[d] = 16'(d * A_const);
    end

    // Multiples are monotonic in d, so the last passing compare is the largest digit.
    always_comb begin
        dig_hi = '0;
        dig_lo = '0;
        for (int d = 1; d < 16; d++) begin
            if ({lut[d][11:0], 4'h0} <= p_q) dig_hi = 4'(d);
            if (lut[d] <= p_q)               dig_lo = 4'(d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StHi;
            StHi:    state_d = StLo;
            StLo:    state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q <= '0;
            x_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (in_valid) p_q <= C;
                StHi: begin
                    x_q[7:4] <= dig_hi;
                    p_q      <= p_q - {lut[dig_hi][11:0], 4'h0};
                end
                StLo: begin
                    x_q[3:0] <= dig_lo;
                    p_q      <= p_q - lut[dig_lo];
                end
                default: ;
            endcase
        end
    end

`ifdef LUT_DIV_OVF_CHECK_EN
    localparam logic [15:0] OvfLimit = 16'(A_const * 256);

    always_ff @(posedge clk) begin
        if (!rst_n)                             ovf_q <= 1'b0;
        else if (state_q == StIdle && in_valid) ovf_q <= (C >= OvfLimit);
    end
`else
    assign ovf_q = 1'b0;
`endif

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        X         = x_q;
        R         = p_q[7:0];
        ovf       = 1'b0;
        if (state_q == StDone && ovf_q) begin
            X   = 8'hFF;
            R   = 8'h00;
            ovf = 1'b1;
        end
    end

endmodule

// File: tb/tb_lut_const_div_8bit.sv
// Directed bench for lut_const_div_8bit: three instances with A_const = 2, 7 and 1.
module tb_lut_const_div_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_a [3];
    logic        in_ready_a [3];
    logic [15:0] c_a        [3];
    logic        out_valid_a[3];
    logic        out_ready_a[3];
    logic [7:0]  x_a        [3];
    logic [7:0]  r_a        [3];
    logic        ovf_a      [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lut_const_div_8bit #(.A_const(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .C(c_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .X(x_a[0]), .R(r_a[0]), .ovf(ovf_a[0])
    );

    lut_const_div_8bit #(.A_const(7)) u_div7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .C(c_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .X(x_a[1]), .R(r_a[1]), .ovf(ovf_a[1])
    );

    lut_const_div_8bit #(.A_const(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .C(c_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .X(x_a[2]), .R(r_a[2]), .ovf(ovf_a[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic start_op(input int s, input logic [15:0] c);
        @(negedge clk);
        check_eq("in_ready_before_accept", 32'(in_ready_a[s]), 1);
        in_valid_a[s] = 1'b1;
        c_a[s]        = c;
    endtask

    // Counts negedges after the accept edge; result must appear on the third.
    task automatic wait_result(input int s, input int ex, input int er, input int eo,
                               input string tag);
        int cnt = 0;
        do begin
            @(negedge clk);
            in_valid_a[s] = 1'b0;
            cnt++;
        end while (!out_valid_a[s] && cnt < 10);
        check_eq({tag, "_latency"}, 32'(cnt), 3);
        check_eq({tag, "_X"}, 32'(x_a[s]), 32'(ex));
        check_eq({tag, "_R"}, 32'(r_a[s]), 32'(er));
        check_eq({tag, "_ovf"}, 32'(ovf_a[s]), 32'(eo));
    endtask

    task automatic release_result(input int s, input string tag);
        out_ready_a[s] = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready_after"}, 32'(in_ready_a[s]), 1);
        check_eq({tag, "_out_valid_after"}, 32'(out_valid_a[s]), 0);
        out_ready_a[s] = 1'b0;
    endtask

    initial begin
        int seen;
        int cyc;
        int nres;
        logic [7:0] rx [2];
        logic [7:0] rr [2];
        int rc [2];

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid_a[s]  = 1'b0;
            c_a[s]         = '0;
            out_ready_a[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_eq("rst_in_ready", 32'(in_ready_a[s]), 1);
            check_eq("rst_out_valid", 32'(out_valid_a[s]), 0);
            check_eq("rst_X", 32'(x_a[s]), 0);
            check_eq("rst_R", 32'(r_a[s]), 0);
            check_eq("rst_ovf", 32'(ovf_a[s]), 0);
        end
        rst_n = 1'b1;

        start_op(0, 16'd200);  wait_result(0, 100, 0, 0, "a2_c200");   release_result(0, "a2_c200");
        start_op(1, 16'd1000); wait_result(1, 142, 6, 0, "a7_c1000");  release_result(1, "a7_c1000");
        start_op(0, 16'd511);  wait_result(0, 255, 1, 0, "a2_c511");   release_result(0, "a2_c511");
        start_op(0, 16'd0);    wait_result(0, 0, 0, 0, "a2_c0");       release_result(0, "a2_c0");
        start_op(1, 16'd1791); wait_result(1, 255, 6, 0, "a7_c1791");  release_result(1, "a7_c1791");
`ifdef LUT_DIV_OVF_CHECK_EN
        start_op(0, 16'd512);  wait_result(0, 255, 0, 1, "a2_c512");   release_result(0, "a2_c512");
`endif

        // Backpressure: result held, a new request during DONE must be ignored.
        start_op(0, 16'd9);
        wait_result(0, 4, 1, 0, "bp");
        in_valid_a[0] = 1'b1;
        c_a[0]        = 16'd100;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_hold_X", 32'(x_a[0]), 4);
            check_eq("bp_hold_R", 32'(r_a[0]), 1);
            check_eq("bp_hold_out_valid", 32'(out_valid_a[0]), 1);
            check_eq("bp_hold_in_ready", 32'(in_ready_a[0]), 0);
        end
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b0;
        @(negedge clk);
        check_eq("bp_in_ready_after", 32'(in_ready_a[0]), 1);
        check_eq("bp_out_valid_after", 32'(out_valid_a[0]), 0);
        out_ready_a[0] = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_a[0] || !in_ready_a[0]) seen = 1;
        end
        check_eq("bp_no_spurious_op", 32'(seen), 0);

        // Reset asserted while in LO abandons the operation.
        start_op(0, 16'd200);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstlo_in_ready", 32'(in_ready_a[0]), 1);
        check_eq("rstlo_out_valid", 32'(out_valid_a[0]), 0);
        check_eq("rstlo_X", 32'(x_a[0]), 0);
        check_eq("rstlo_R", 32'(r_a[0]), 0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_a[0]) seen = 1;
        end
        check_eq("rstlo_no_stale", 32'(seen), 0);

        // Back-to-back with A_const = 1 and out_ready tied high.
        out_ready_a[2] = 1'b1;
        @(negedge clk);
        in_valid_a[2] = 1'b1;
        c_a[2]        = 16'd0;
        @(negedge clk);
        c_a[2] = 16'd255;
        cyc    = 1;
        nres   = 0;
        while (nres < 2 && cyc < 20) begin
            if (out_valid_a[2]) begin
                rx[nres] = x_a[2];
                rr[nres] = r_a[2];
                rc[nres] = cyc;
                nres++;
                if (nres == 2) in_valid_a[2] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid_a[2]  = 1'b0;
        out_ready_a[2] = 1'b0;
        check_eq("b2b_count", 32'(nres), 2);
        if (nres == 2) begin
            check_eq("b2b_first_lat", 32'(rc[0]), 3);
            check_eq("b2b_X0", 32'(rx[0]), 0);
            check_eq("b2b_R0", 32'(rr[0]), 0);
            check_eq("b2b_X1", 32'(rx[1]), 255);
            check_eq("b2b_R1", 32'(rr[1]), 0);
            check_eq("b2b_spacing", 32'(rc[1] - rc[0]), 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
